// File: rtl/branch_predict_resolve_pkg.sv
// Shared branch-type codes and saturating-counter init helpers for the branch unit.
package branch_predict_resolve_pkg;

   typedef enum logic [2:0] {
      BR_NOBRANCH = 3'd0,
      BR_BEQ      = 3'd1,
      BR_BNE      = 3'd2,
      BR_BLT      = 3'd3,
      BR_BLTU     = 3'd4,
      BR_BGE      = 3'd5,
      BR_BGEU     = 3'd6
   } br_type_e;

   // Weakly-not-taken is one below the MSB-set threshold; weakly-taken is exactly the threshold.
   function automatic int unsigned ctr_weak_nt(input int unsigned bits);
      return (32'd1 << (bits - 1)) - 32'd1;
   endfunction

   function automatic int unsigned ctr_weak_t(input int unsigned bits);
      return 32'd1 << (bits - 1);
   endfunction

endpackage

// File: rtl/branch_predict_resolve_compare.sv
// branch_compare: combinational branch-condition evaluation for one branch type and two operands.
module branch_compare
   import branch_predict_resolve_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [2:0]      br_type,
   input  logic [XLEN-1:0] op1,
   input  logic [XLEN-1:0] op2,
   output logic            taken
);

   br_type_e t;
   assign t = br_type_e'(br_type);

   always_comb begin
      taken = 1'b0;
      case (t)
         BR_BEQ:  taken = (op1 == op2);
         BR_BNE:  taken = (op1 != op2);
         BR_BLT:  taken = ($signed(op1) <  $signed(op2));
         BR_BLTU: taken = (op1 <  op2);
         BR_BGE:  taken = ($signed(op1) >= $signed(op2));
         BR_BGEU: taken = (op1 >= op2);
         default: taken = 1'b0;   // NOBRANCH and the unused code 7
      endcase
   end

endmodule

// File: rtl/branch_predict_resolve.sv
// Branch unit: direct-mapped BTB with saturating counters, EX-stage resolve and training.
// Optional resolve/mispredict counters are built when BRANCH_STATS_EN is defined.
module branch_predict_resolve
   import branch_predict_resolve_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int ENTRIES  = 64,
   parameter int CTR_BITS = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [XLEN-1:0] PCF,
   output logic            PredTakenF,
   output logic [XLEN-1:0] PredTargetF,
   input  logic            ValidE,
   input  logic            StallE,
   input  logic [2:0]      BranchTypeE,
   input  logic [XLEN-1:0] Operand1,
   input  logic [XLEN-1:0] Operand2,
   input  logic [XLEN-1:0] PCE,
   input  logic [XLEN-1:0] BrTargetE,
   input  logic            PredTakenE,
   input  logic [XLEN-1:0] PredTargetE,
   output logic            BranchE,
   output logic            MispredictE,
   output logic [XLEN-1:0] RedirectPCE,
   output logic [31:0]     BrCount,
   output logic [31:0]     MissCount
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = XLEN - IDX_W - 2;
   localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_BITS'(ctr_weak_nt(CTR_BITS));
   localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(ctr_weak_t(CTR_BITS));
   localparam logic [CTR_BITS-1:0] CTR_MAX = '1;

   logic                valid_q  [ENTRIES];
   logic [TAG_W-1:0]    tag_q    [ENTRIES];
   logic [XLEN-1:0]     target_q [ENTRIES];
   logic [CTR_BITS-1:0] ctr_q    [ENTRIES];

   // Fetch-side lookup; PC[1:0] never participates.
   logic [IDX_W-1:0] idx_f;
   logic [TAG_W-1:0] tag_f;
   logic             hit_f;
   logic             unused_pcf_lsb;

   assign idx_f          = PCF[IDX_W+1:2];
   assign tag_f          = PCF[XLEN-1:IDX_W+2];
   assign hit_f          = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
   assign PredTakenF     = hit_f && ctr_q[idx_f][CTR_BITS-1];
   assign PredTargetF    = target_q[idx_f];
   assign unused_pcf_lsb = &{1'b0, PCF[1:0]};

   logic cond_taken;

   branch_compare #(.XLEN(XLEN)) u_compare (
      .br_type (BranchTypeE),
      .op1     (Operand1),
      .op2     (Operand2),
      .taken   (cond_taken)
   );

   // active: EX holds a real branch (outputs are meaningful).
   // resolve: active and EX advances this cycle, so the table and stats may train.
   logic active;
   logic resolve;

   assign active  = ValidE && (BranchTypeE != BR_NOBRANCH);
   assign resolve = active && !StallE;

   always_comb begin
      BranchE     = 1'b0;
      MispredictE = 1'b0;
      RedirectPCE = '0;
      if (active) begin
         BranchE     = cond_taken;
         MispredictE = (cond_taken != PredTakenE) || (cond_taken && (PredTargetE != BrTargetE));
         RedirectPCE = cond_taken ? BrTargetE : PCE + XLEN'(4);
      end
   end

   logic [IDX_W-1:0] idx_e;
   logic [TAG_W-1:0] tag_e;
   logic             hit_e;

   assign idx_e = PCE[IDX_W+1:2];
   assign tag_e = PCE[XLEN-1:IDX_W+2];
   assign hit_e = valid_q[idx_e] && (tag_q[idx_e] == tag_e);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i]  <= 1'b0;
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            ctr_q[i]    <= CTR_WNT;
         end
      end else if (resolve) begin
         if (BranchE) begin
            target_q[idx_e] <= BrTargetE;
            if (hit_e) begin
               if (ctr_q[idx_e] != CTR_MAX) ctr_q[idx_e] <= ctr_q[idx_e] + 1'b1;
            end else begin
               // Allocation overwrites whatever aliased into this slot.
               valid_q[idx_e] <= 1'b1;
               tag_q[idx_e]   <= tag_e;
               ctr_q[idx_e]   <= CTR_WT;
            end
         end else if (hit_e && (ctr_q[idx_e] != '0)) begin
            ctr_q[idx_e] <= ctr_q[idx_e] - 1'b1;
         end
      end
   end

`ifdef BRANCH_STATS_EN
   logic [31:0] br_cnt_q;
   logic [31:0] miss_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         br_cnt_q   <= '0;
         miss_cnt_q <= '0;
      end else if (resolve) begin
         br_cnt_q <= br_cnt_q + 32'd1;
         if (MispredictE) miss_cnt_q <= miss_cnt_q + 32'd1;
      end
   end

   assign BrCount   = br_cnt_q;
   assign MissCount = miss_cnt_q;
`else
   assign BrCount   = '0;
   assign MissCount = '0;
`endif

endmodule

// File: tb/tb_branch_predict_resolve.sv
// Bench for branch_predict_resolve: directed scenarios then random traffic against a table model.
module tb_branch_predict_resolve;

   localparam int XLEN     = 32;
   localparam int ENTRIES  = 64;
   localparam int CTR_BITS = 2;
   localparam int CTR_TOP  = (1 << CTR_BITS) - 1;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [XLEN-1:0] pcf = '0;
   logic            pred_taken_f;
   logic [XLEN-1:0] pred_target_f;
   logic            valid_e = 1'b0;
   logic            stall_e = 1'b0;
   logic [2:0]      branch_type_e = 3'd0;
   logic [XLEN-1:0] operand1 = '0;
   logic [XLEN-1:0] operand2 = '0;
   logic [XLEN-1:0] pce = '0;
   logic [XLEN-1:0] br_target_e = '0;
   logic            pred_taken_e = 1'b0;
   logic [XLEN-1:0] pred_target_e = '0;
   logic            branch_e;
   logic            mispredict_e;
   logic [XLEN-1:0] redirect_pc_e;
   logic [31:0]     br_count;
   logic [31:0]     miss_count;

   always #5 clk = ~clk;

   branch_predict_resolve #(.XLEN(XLEN), .ENTRIES(ENTRIES), .CTR_BITS(CTR_BITS)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .PCF         (pcf),
      .PredTakenF  (pred_taken_f),
      .PredTargetF (pred_target_f),
      .ValidE      (valid_e),
      .StallE      (stall_e),
      .BranchTypeE (branch_type_e),
      .Operand1    (operand1),
      .Operand2    (operand2),
      .PCE         (pce),
      .BrTargetE   (br_target_e),
      .PredTakenE  (pred_taken_e),
      .PredTargetE (pred_target_e),
      .BranchE     (branch_e),
      .MispredictE (mispredict_e),
      .RedirectPCE (redirect_pc_e),
      .BrCount     (br_count),
      .MissCount   (miss_count)
   );

   // Scoreboard
   int n_vec = 0;
   int n_err = 0;
   logic [31:0] exp_q[$];

   task automatic chk(input string tag, input logic [31:0] got);
      logic [31:0] exp;
      exp = exp_q.pop_front();
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference model: one record per table slot, counter kept as a plain integer.
   bit          m_valid [ENTRIES];
   int unsigned m_tag   [ENTRIES];
   int unsigned m_tgt   [ENTRIES];
   int          m_ctr   [ENTRIES];
   int unsigned m_br;
   int unsigned m_miss;

   task automatic model_reset();
      for (int i = 0; i < ENTRIES; i++) begin
         m_valid[i] = 1'b0;
         m_tag[i]   = 0;
         m_tgt[i]   = 0;
         m_ctr[i]   = (1 << (CTR_BITS - 1)) - 1;
      end
      m_br   = 0;
      m_miss = 0;
   endtask

   function automatic int slot_of(input logic [31:0] pc);
      return int'((pc / 4) % ENTRIES);
   endfunction

   function automatic int unsigned tag_of(input logic [31:0] pc);
      return pc / (4 * ENTRIES);
   endfunction

   function automatic bit model_hit(input logic [31:0] pc);
      return m_valid[slot_of(pc)] && (m_tag[slot_of(pc)] == tag_of(pc));
   endfunction

   function automatic bit model_pred(input logic [31:0] pc);
      return model_hit(pc) && (m_ctr[slot_of(pc)] >= (1 << (CTR_BITS - 1)));
   endfunction

   function automatic bit ref_taken(input logic [2:0] bt, input logic [31:0] a, input logic [31:0] b);
      int sa, sb;
      sa = int'(a);
      sb = int'(b);
      case (bt)
         3'd1:    return a == b;
         3'd2:    return a != b;
         3'd3:    return sa < sb;
         3'd4:    return a < b;
         3'd5:    return sa >= sb;
         3'd6:    return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   task automatic model_train(input logic [31:0] pc, input bit taken, input logic [31:0] tgt);
      int s;
      s = slot_of(pc);
      if (taken) begin
         if (model_hit(pc)) begin
            if (m_ctr[s] < CTR_TOP) m_ctr[s]++;
         end else begin
            m_valid[s] = 1'b1;
            m_tag[s]   = tag_of(pc);
            m_ctr[s]   = 1 << (CTR_BITS - 1);
         end
         m_tgt[s] = tgt;
      end else if (model_hit(pc) && m_ctr[s] > 0) begin
         m_ctr[s]--;
      end
   endtask

   function automatic logic [31:0] exp_stat(input int unsigned v);
`ifdef BRANCH_STATS_EN
      return v;
`else
      return 32'd0 & v;
`endif
   endfunction

   // Apply one EX/IF cycle, check all combinational outputs mid-cycle, then advance the model.
   task automatic step(input logic [2:0] bt, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] pc_e, input logic [31:0] tgt, input bit v, input bit st,
                       input bit pte, input logic [31:0] ptge, input logic [31:0] pc_f);
      bit act, tk, br, mis, pt;
      logic [31:0] red;
      branch_type_e = bt;  operand1 = a;  operand2 = b;  pce = pc_e;  br_target_e = tgt;
      valid_e = v;  stall_e = st;  pred_taken_e = pte;  pred_target_e = ptge;  pcf = pc_f;
      #2;
      act = v && (bt != 3'd0);
      tk  = ref_taken(bt, a, b);
      br  = act && tk;
      mis = act && ((br != pte) || (br && ptge != tgt));
      red = !act ? 32'd0 : (br ? tgt : pc_e + 32'd4);
      pt  = model_pred(pc_f);
      exp_q.push_back({31'd0, br});   chk("BranchE", {31'd0, branch_e});
      exp_q.push_back({31'd0, mis});  chk("MispredictE", {31'd0, mispredict_e});
      exp_q.push_back(red);           chk("RedirectPCE", redirect_pc_e);
      exp_q.push_back({31'd0, pt});   chk("PredTakenF", {31'd0, pred_taken_f});
      if (pt) begin
         exp_q.push_back(m_tgt[slot_of(pc_f)]);
         chk("PredTargetF", pred_target_f);
      end
      exp_q.push_back(exp_stat(m_br));   chk("BrCount", br_count);
      exp_q.push_back(exp_stat(m_miss)); chk("MissCount", miss_count);
      @(posedge clk);
      if (act && !st) begin
         model_train(pc_e, tk, tgt);
         m_br++;
         if (mis) m_miss++;
      end
      #1;
   endtask

   task automatic idle(input logic [31:0] pc_f);
      step(3'd0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 0, pc_f);
   endtask

   // Asynchronous reset asserted mid-cycle; checks the cleared state while held.
   task automatic do_reset();
      valid_e = 1'b0;
      pcf = 32'h100;
      rst_n = 1'b0;
      model_reset();
      #2;
      exp_q.push_back(32'd0); chk("reset PredTakenF", {31'd0, pred_taken_f});
      exp_q.push_back(32'd0); chk("reset BrCount", br_count);
      exp_q.push_back(32'd0); chk("reset MissCount", miss_count);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   logic [31:0] pool [8] = '{32'h100, 32'h200, 32'h104, 32'h300, 32'h1100, 32'h40, 32'h44, 32'hFFFF_FFFC};

   initial begin
      model_reset();
      #3;
      do_reset();

      // Cold taken branch allocates; the next lookup predicts it.
      step(3'd1, 5, 5, 32'h100, 32'h140, 1, 0, 0, 0, 32'h100);
      idle(32'h100);

      // Saturate, then one not-taken keeps it predicting taken.
      for (int i = 0; i < 3; i++) step(3'd1, 5, 5, 32'h100, 32'h140, 1, 0, 1, 32'h140, 32'h100);
      step(3'd1, 5, 6, 32'h100, 32'h140, 1, 0, 1, 32'h140, 32'h100);
      idle(32'h100);

      // Compare corners and PC+4 wrap.
      step(3'd3, 32'hFFFF_FFFF, 1, 32'h1000, 32'h1040, 1, 0, 0, 0, 32'h1000);
      step(3'd4, 32'hFFFF_FFFF, 1, 32'h1004, 32'h1040, 1, 0, 0, 0, 32'h1004);
      step(3'd5, 32'h8000_0000, 0, 32'h1008, 32'h1040, 1, 0, 0, 0, 32'h1000);
      step(3'd6, 32'h8000_0000, 0, 32'h100C, 32'h1040, 1, 0, 0, 0, 32'h100C);
      step(3'd7, 3, 3, 32'h1010, 32'h1040, 1, 0, 0, 0, 32'h1010);
      step(3'd2, 7, 7, 32'hFFFF_FFFC, 32'h40, 1, 0, 0, 0, 32'h1000);

      // Aliasing: 0x200 evicts 0x100.
      step(3'd1, 1, 1, 32'h200, 32'h280, 1, 0, 0, 0, 32'h100);
      idle(32'h100);
      idle(32'h200);

      // Stalled branch does not train; invalid EX never mispredicts.
      for (int i = 0; i < 3; i++) step(3'd1, 9, 9, 32'h300, 32'h340, 1, 1, 0, 0, 32'h300);
      idle(32'h300);
      step(3'd1, 9, 9, 32'h300, 32'h340, 0, 0, 1, 32'h999, 32'h300);

      // Stats run: 10 branches, first 4 mispredict, then reset mid-run.
      do_reset();
      for (int i = 0; i < 10; i++)
         step(3'd1, i, (i < 4) ? i : i + 1, 32'h2000 + 32'(i * 4), 32'h3000, 1, 0, 0, 0, 32'h2000);
      idle(32'h2000);
      do_reset();
      idle(32'h2000);

      // Random traffic, prediction mostly taken from the model as a real pipeline would.
      for (int n = 0; n < 400; n++) begin
         logic [2:0]  bt;
         logic [31:0] a, b, pc_e, tgt, ptge;
         bit v, st, pte;
         bt   = 3'($urandom_range(0, 7));
         a    = $urandom;
         b    = ($urandom_range(0, 3) == 0) ? a : (($urandom_range(0, 1) == 0) ? $urandom : a ^ 32'h8000_0000);
         pc_e = pool[$urandom_range(0, 7)];
         tgt  = ($urandom_range(0, 1) == 0) ? pool[$urandom_range(0, 7)] : ($urandom & 32'hFFFF_FFFC);
         v    = ($urandom_range(0, 9) != 0);
         st   = ($urandom_range(0, 6) == 0);
         pte  = model_pred(pc_e);
         ptge = m_tgt[slot_of(pc_e)];
         if ($urandom_range(0, 7) == 0) pte = !pte;
         if ($urandom_range(0, 7) == 0) ptge = $urandom;
         step(bt, a, b, pc_e, tgt, v, st, pte, ptge, pool[$urandom_range(0, 7)]);
         if ($urandom_range(0, 199) == 0) do_reset();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
